// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_arbiter
// Description : Shares the single-port data memory between the core data port
//               and a debug/loader port, one access in flight at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int              SW         = $clog2(MAX_BURST + 1);
  localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_BURST);

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state;
  logic [SW-1:0] streak;
  logic          win_dbg;
  logic          pick_dbg;

  // Core wins ties until it has used up its burst allowance against a waiting dbg.
  assign pick_dbg   = dbg_req && (!core_req || (streak == STREAK_MAX));
  assign busy       = (state != ARB);
  assign core_rdata = core_rvalid ? mem_rdata : '0;
  assign dbg_rdata  = dbg_rvalid  ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ARB;
      streak      <= '0;
      win_dbg     <= 1'b0;
      core_gnt    <= 1'b0;
      dbg_gnt     <= 1'b0;
      core_rvalid <= 1'b0;
      dbg_rvalid  <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      core_gnt    <= 1'b0;
      dbg_gnt     <= 1'b0;
      core_rvalid <= 1'b0;
      dbg_rvalid  <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      case (state)
        ARB: begin
          if (!dbg_req) streak <= '0;
          if (core_req || dbg_req) begin
            state   <= ACCESS;
            win_dbg <= pick_dbg;
            mem_en  <= 1'b1;
            // The mem_* registers double as the latched request fields.
            if (pick_dbg) begin
              dbg_gnt   <= 1'b1;
              mem_we    <= dbg_we;
              mem_addr  <= dbg_addr;
              mem_wdata <= dbg_wdata;
              streak    <= '0;
            end else begin
              core_gnt  <= 1'b1;
              mem_we    <= core_we;
              mem_addr  <= core_addr;
              mem_wdata <= core_wdata;
              if (dbg_req && (streak != STREAK_MAX)) streak <= streak + 1'b1;
            end
          end
        end
        ACCESS: begin
          if (mem_we) begin
            state <= ARB;
          end else begin
            state       <= RESP;
            core_rvalid <= !win_dbg;
            dbg_rvalid  <= win_dbg;
          end
        end
        RESP:    state <= ARB;
        default: state <= ARB;
      endcase
    end
  end

endmodule
`default_nettype wire
